wb_pattern_counter: RTL

//  Wishbone-programmable pattern counter in the user project area. It drives the 4-bit

---
 rtl/wb_pattern_counter_pkg.sv | 31 +++
 rtl/pattern_prescaler.sv | 35 +++
 rtl/wb_pattern_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_pattern_counter_pkg.sv
// Shared definitions for the Wishbone pattern counter: register offsets,
// CTRL bit positions, pattern modes and the per-mode seed rule.
package wb_pattern_counter_pkg;

  // Register offsets within the 256-byte window (adr[7:0]).
  localparam logic [7:0] ADR_CTRL     = 8'h00;
  localparam logic [7:0] ADR_PRESCALE = 8'h04;
  localparam logic [7:0] ADR_COUNT    = 8'h08;
  localparam logic [7:0] ADR_STATUS   = 8'h0C;

  // CTRL bit positions; all live in byte lane 0.
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_OE       = 3;
  localparam int CTRL_CLEAR    = 4;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_DOWN    = 2'b11
  } mode_e;

  // Every mode seeds to zero except the one-hot ring, which seeds to 1.
  // Returning only the LSB keeps the helper independent of pattern width.
  function automatic logic seed_lsb(input mode_e mode);
    return (mode == MODE_RING);
  endfunction

endpackage

// File: rtl/pattern_prescaler.sv
// Step-rate prescaler for the pattern counter.
// Ports:
//   clock  in   rising-edge clock
//   resetb in   asynchronous active-low reset
//   en     in   count enable; while low the divider sits at 0
//   clr    in   synchronous clear of the divider
//   limit  in   terminal count; one tick every limit+1 enabled clocks
//   tick   out  high during the cycle whose closing edge steps the pattern
module pattern_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_reg;

  // Combinational so the step lands on the same edge that wraps the divider.
  assign tick = en && (div_reg == limit);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      div_reg <= '0;
    end else if (clr || !en || tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_pattern_counter.sv
// Wishbone-programmable pattern counter driving the user IO pads.
// Ports:
//   clock, resetb         clock and asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i  Wishbone control; sel_i byte enables for writes
//   wbs_adr_i, wbs_dat_i  byte address and write data
//   wbs_ack_o, wbs_dat_o  single-cycle acknowledge and registered read data
//   pat_o                 current pattern
//   pat_oeb_o             pad output-enable bar (all bits = ~CTRL.oe)
//   tick_o                one pulse per pattern step
module wb_pattern_counter
  import wb_pattern_counter_pkg::*;
#(
  parameter int          WIDTH      = 4,
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] pat_o,
  output logic [WIDTH-1:0] pat_oeb_o,
  output logic             tick_o
);

  localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]       STATUS_MAX = 8'hFF;

  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic                  en_reg;
  logic                  oe_reg;
  mode_e                 mode_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PRESCALE_W-1:0] prescale_next;
  logic [WIDTH-1:0]      pat_reg;
  logic [WIDTH-1:0]      pat_next;
  logic [7:0]            status_reg;
  logic [7:0]            status_next;

  logic                  access, hit, wr, rd;
  logic                  ctrl_wr, pre_wr, count_wr, clear, seed_load;
  mode_e                 mode_wr_val, mode_next;
  logic [WIDTH-1:0]      seed_val, step_val;
  logic                  wrap, tick;
  logic [31:0]           rd_data;
  logic                  unused_dat;

  // A new access is only taken while ack is low, so held strobes ack 1,0,1,0.
  assign access = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign hit    = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wr     = access & hit & wbs_we_i;
  assign rd     = access & hit & ~wbs_we_i;

  assign ctrl_wr  = wr & (wbs_adr_i[7:0] == ADR_CTRL) & wbs_sel_i[0];
  assign pre_wr   = wr & (wbs_adr_i[7:0] == ADR_PRESCALE) & (|wbs_sel_i);
  assign count_wr = wr & (wbs_adr_i[7:0] == ADR_COUNT) & wbs_sel_i[0];

  assign mode_wr_val = mode_e'(wbs_dat_i[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  assign mode_next   = ctrl_wr ? mode_wr_val : mode_reg;
  assign clear       = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
  assign seed_load   = ctrl_wr & (mode_wr_val != mode_reg);
  // Clear and mode-change both seed from the mode in force after this write.
  assign seed_val    = {{(WIDTH-1){1'b0}}, seed_lsb(mode_next)};

  // Per-bit byte-lane merge for the prescale register.
  genvar gi;
  generate
    for (gi = 0; gi < PRESCALE_W; gi++) begin : g_pre_lane
      assign prescale_next[gi] = wbs_sel_i[gi/8] ? wbs_dat_i[gi] : prescale_reg[gi];
    end
  endgenerate

  assign unused_dat = ^wbs_dat_i;

  pattern_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock  (clock),
    .resetb (resetb),
    .en     (en_reg),
    .clr    (clear | pre_wr),
    .limit  (prescale_reg),
    .tick   (tick)
  );

  // Next pattern and wrap flag for the current mode.
  always_comb begin
    step_val = pat_reg;
    wrap     = 1'b0;
    case (mode_reg)
      MODE_UP: begin
        step_val = pat_reg + 1'b1;
        wrap     = &pat_reg;
      end
      MODE_RING: begin
        step_val = {pat_reg[WIDTH-2:0], pat_reg[WIDTH-1]};
        wrap     = (pat_reg == MSB_ONLY);
      end
      MODE_JOHNSON: begin
        step_val = {pat_reg[WIDTH-2:0], ~pat_reg[WIDTH-1]};
        wrap     = (pat_reg == MSB_ONLY);
      end
      default: begin
        step_val = pat_reg - 1'b1;
        wrap     = ~|pat_reg;
      end
    endcase
  end

  // Clear beats any write, writes beat the tick step; an overridden step
  // never reaches STATUS.
  always_comb begin
    pat_next    = pat_reg;
    status_next = status_reg;
    if (clear) begin
      pat_next    = seed_val;
      status_next = '0;
    end else if (count_wr) begin
      pat_next = wbs_dat_i[WIDTH-1:0];
    end else if (seed_load) begin
      pat_next = seed_val;
    end else if (tick) begin
      pat_next = step_val;
      if (wrap && (status_reg != STATUS_MAX)) begin
        status_next = status_reg + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[7:0])
      ADR_CTRL: begin
        rd_data[CTRL_EN]                     = en_reg;
        rd_data[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_reg;
        rd_data[CTRL_OE]                     = oe_reg;
      end
      ADR_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale_reg;
      ADR_COUNT:    rd_data[WIDTH-1:0]      = pat_reg;
      ADR_STATUS:   rd_data[7:0]            = status_reg;
      default:      rd_data                 = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      en_reg       <= 1'b0;
      oe_reg       <= 1'b0;
      mode_reg     <= MODE_UP;
      prescale_reg <= '0;
      pat_reg      <= '0;
      status_reg   <= '0;
    end else begin
      ack_reg <= access;
      dat_reg <= rd ? rd_data : '0;
      if (ctrl_wr) begin
        en_reg   <= wbs_dat_i[CTRL_EN];
        mode_reg <= mode_wr_val;
        oe_reg   <= wbs_dat_i[CTRL_OE];
      end
      if (pre_wr) begin
        prescale_reg <= prescale_next;
      end
      pat_reg    <= pat_next;
      status_reg <= status_next;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign pat_o     = pat_reg;
  assign pat_oeb_o = {WIDTH{~oe_reg}};
  assign tick_o    = tick;

endmodule
